// File: rtl/dot_update_scheduler.sv
// Buffers processor dot-position writes and replays them to the display registers
// only during vertical blanking, then acknowledges the frame to the processor.
module dot_update_scheduler #(
   parameter int NUM_DOTS   = 20,
   parameter int FIFO_DEPTH = 32,
   parameter int ID_WIDTH   = 5,
   parameter int X_MAX      = 639,
   parameter int Y_MAX      = 479
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          dotWren,
   input  logic                          is_Yloc,
   input  logic [31:0]                   dotID,
   input  logic [31:0]                   dotLoc,
   output logic                          wr_ready,
   input  logic                          screenEnd,
   output logic                          commit_valid,
   output logic                          commit_is_y,
   output logic [ID_WIDTH-1:0]           commit_id,
   output logic [9:0]                    commit_loc,
   output logic                          frame_ack,
   output logic [$clog2(FIFO_DEPTH):0]   pending,
   output logic                          err_overflow,
   output logic                          err_bad_id,
   output logic                          err_late,
   output logic [15:0]                   frame_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = 1 + ID_WIDTH + 10;
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef enum logic [1:0] {IDLE, DRAIN, ACK} state_t;

   state_t          state, next_state;
   logic [EW-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count, budget;
   logic            screen_q, screen_edge;
   logic            bad_id, full, push, pop, load_budget;
   logic [9:0]      loc_clamped;

   assign screen_edge = screenEnd & ~screen_q;
   assign bad_id      = (dotID >= 32'(NUM_DOTS));
   assign full        = (count == CNT_FULL);
   assign pop         = (state == DRAIN);
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
   assign push        = dotWren & ~bad_id & (~full | pop);
   assign wr_ready    = ~full;
   assign pending     = count;

   always_comb begin
      loc_clamped = dotLoc[9:0];
      if (is_Yloc) begin
         if (dotLoc > 32'(Y_MAX)) loc_clamped = 10'(Y_MAX);
      end else begin
         if (dotLoc > 32'(X_MAX)) loc_clamped = 10'(X_MAX);
      end
   end

   always_comb begin
      next_state  = state;
      load_budget = 1'b0;
      case (state)
         IDLE: begin
            if (screen_edge) begin
               load_budget = 1'b1;
               next_state  = (count != '0) ? DRAIN : ACK;
            end
         end
         DRAIN:   if (budget == CNT_ONE) next_state = ACK;
         ACK:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {is_Yloc, dotID[ID_WIDTH-1:0], loc_clamped};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         budget       <= '0;
         screen_q     <= 1'b0;
         commit_valid <= 1'b0;
         commit_is_y  <= 1'b0;
         commit_id    <= '0;
         commit_loc   <= '0;
         frame_ack    <= 1'b0;
         frame_count  <= '0;
         err_overflow <= 1'b0;
         err_bad_id   <= 1'b0;
         err_late     <= 1'b0;
      end else begin
         state    <= next_state;
         screen_q <= screenEnd;
         // Budget is the occupancy before this cycle's push, so late writes wait a frame
         if (load_budget)  budget <= count;
         else if (pop)     budget <= budget - CNT_ONE;
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      count <= count + CNT_ONE;
         else if (pop && !push) count <= count - CNT_ONE;
         commit_valid <= pop;
         if (pop) {commit_is_y, commit_id, commit_loc} <= mem[rd_ptr];
         frame_ack <= (state == ACK);
         if (state == ACK) frame_count <= frame_count + 16'd1;
         if (dotWren && bad_id)                 err_bad_id   <= 1'b1;
         if (dotWren && !bad_id && full && !pop) err_overflow <= 1'b1;
         if (screen_edge && state != IDLE)      err_late     <= 1'b1;
      end
   end

endmodule

// File: doc/dot_update_scheduler.md
Name: dot_update_scheduler

Overview:
- Sits between the processor's dot-write port and the VGA display's dot-position registers.
- Buffers processor dot-position writes in a FIFO. Commits them to the display only during vertical blanking, so a frame never shows half-updated dot positions.
- Pulses a frame acknowledge to the processor after each blanking-interval commit, so software can pace its per-frame dot updates.

Parameters:
- NUM_DOTS, 20, number of dots; valid ids are 0..NUM_DOTS-1.
- FIFO_DEPTH, 32, write-buffer entries; must be a power of 2.
- ID_WIDTH, 5, width of the committed dot id; must satisfy 2^ID_WIDTH >= NUM_DOTS.
- X_MAX, 639, largest legal x coordinate.
- Y_MAX, 479, largest legal y coordinate.

Ports:
- clk  in  1  100 MHz system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- dotWren  in  1  processor write strobe; one push per cycle it is high.
- is_Yloc  in  1  1 = write y coordinate, 0 = write x coordinate.
- dotID  in  32  target dot id.
- dotLoc  in  32  coordinate value.
- wr_ready  out  1  FIFO not full.
- screenEnd  in  1  frame-boundary level from the timing generator (clk25 domain, high for several clk cycles); block acts on its 0->1 edge.
- commit_valid  out  1  one commit this cycle.
- commit_is_y  out  1  commit targets y.
- commit_id  out  ID_WIDTH  dot id being committed.
- commit_loc  out  10  clamped coordinate; bit 9 is 0 for y.
- frame_ack  out  1  one-cycle pulse when the blanking commit completes.
- pending  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- err_overflow  out  1  sticky: a push was dropped because the FIFO was full.
- err_bad_id  out  1  sticky: a push was dropped because dotID >= NUM_DOTS.
- err_late  out  1  sticky: a screenEnd edge arrived while not in IDLE.
- frame_count  out  16  completed commit frames, wraps at 65535 -> 0.

Behaviour:
- Reset, synchronous:
  - state = IDLE; FIFO empty; pending = 0; wr_ready = 1.
  - All commit_* = 0; frame_ack = 0; all err_* = 0; frame_count = 0.
  - screenEnd edge register = 0, so a screenEnd already high during reset is not seen as an edge.
  - A reset mid-DRAIN discards all entries and produces no frame_ack.
- Push (any state):
  - dotID >= NUM_DOTS: drop the write and set err_bad_id.
  - Otherwise, if the FIFO is full: drop the write and set err_overflow.
  - Otherwise store {is_Yloc, dotID[ID_WIDTH-1:0], loc}.
  - loc is clamped at push: x = min(dotLoc[31:0], X_MAX); y = min(dotLoc[31:0], Y_MAX); compare on all 32 bits, unsigned.
- Edge detect: edge = screenEnd & ~screenEnd_q. It is sampled in cycle N.
- FSM:
  - IDLE: on edge, snapshot budget = pending (including a push accepted the same cycle? no: the snapshot excludes the same-cycle push). Go to DRAIN if budget > 0, else go to ACK.
  - DRAIN: pop one entry per cycle. Registered commit_* outputs are valid the cycle after the pop, so the first commit_valid appears at N+2. Decrement budget each pop; when budget reaches 0, go to ACK.
  - ACK: frame_ack = 1 for one cycle; frame_count += 1; return to IDLE.
- Latency: with k entries in the snapshot, commit_valid is high for cycles N+2..N+k+1, with no gaps. frame_ack is high at N+k+2 (at N+2 when k = 0).
- Commit order is FIFO order. A later write to the same dot/axis overwrites the earlier one downstream; no coalescing.
- Pushes during DRAIN/ACK are accepted but not committed until the next frame.
- Simultaneous push and pop: pending is unchanged and a full FIFO accepts the push (the pop frees the slot in the same cycle).
- An edge seen in DRAIN or ACK is ignored and sets err_late.
- Error flags are cleared only by reset.

Test Plan:
- Reset, then push 3 writes (id 2 x=100, id 2 y=50, id 7 x=600), then a screenEnd edge at cycle N. Required: commit_valid at N+2..N+4 in that order with loc 100/50/600; frame_ack at N+5; frame_count = 1; pending = 0.
- Empty FIFO, screenEnd edge at N. Required: no commit_valid; frame_ack at N+2; frame_count increments.
- Push id 20 with NUM_DOTS = 20. Required: dropped, err_bad_id = 1, pending = 0. Push x = 700, y = 500. Required: committed loc 639 and 479.
- Fill the FIFO with 32 pushes. Required: wr_ready = 0. 33rd push: dropped, err_overflow = 1. During DRAIN, pushing every cycle keeps pending = 32 with no overflow. Only the 32 snapshot entries commit before frame_ack.
- Hold screenEnd high for 4 clk cycles. Required: exactly one frame. Give a second edge during DRAIN. Required: err_late = 1 and no extra frame_ack.
- Assert reset at cycle 2 of a 10-entry DRAIN. Required: next cycle all outputs are at reset values and no frame_ack follows.
